bcd_serial_add_ctrl: RTL and testbench

Sequencer that adds two multi-digit packed-BCD operands by time-sharing one single-digit BCD adder, one digit per clock, least-significant digit first. It owns the operand shift registers, decimal carry register and digit counter, and exposes valid/ready handshakes on both sides. It sits between a producer of packed-BCD operand pairs and a consumer of packed-BCD results.

---
 rtl/bcd_pkg.sv | 30 +++
 rtl/bcd_serial_add_ctrl_if.sv | 36 +++
 rtl/bcd_digit_add.sv | 35 +++
 rtl/bcd_serial_add_ctrl.sv | 129 ++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared constants, FSM state type and digit type for the serial
//            packed-BCD adder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    localparam int BCD_W    = 4;
    localparam int BCD_MAX  = 9;
    localparam int BCD_CORR = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    // True for the six 4-bit codes that are not decimal digits.
    function automatic logic digit_invalid(input bcd_digit_t d);
        return d > BCD_W'(BCD_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_serial_add_ctrl_if.sv
// ============================================================================
// Module   : bcd_serial_add_ctrl_if
// Brief    : Operand-in / result-out valid-ready bundle for the serial BCD adder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface bcd_serial_add_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  err;
    logic                  busy;

    // Producer/consumer side.
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, err, busy
    );

    // Adder side.
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, err, busy
    );
endinterface

`default_nettype wire

// File: rtl/bcd_digit_add.sv
// ============================================================================
// Module   : bcd_digit_add
// Brief    : Combinational single-digit BCD adder with decimal carry.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t s,
    output logic       cout
);

    logic [BCD_W:0] w_bin;

    // Binary sums above 9 are pulled back into decimal by adding 6; only the
    // low nibble survives, so out-of-range digits wrap the same way.
    always_comb begin
        w_bin = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
        if (w_bin > (BCD_W+1)'(BCD_MAX)) begin
            s    = w_bin[BCD_W-1:0] + BCD_W'(BCD_CORR);
            cout = 1'b1;
        end else begin
            s    = w_bin[BCD_W-1:0];
            cout = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bcd_serial_add_ctrl.sv
// ============================================================================
// Module   : bcd_serial_add_ctrl
// Brief    : Digit-serial packed-BCD adder, LSD first, one shared digit adder,
//            valid/ready handshakes on operand and result sides.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_serial_add_ctrl_if.slave bus
);

    localparam int SUM_W = BCD_W * DIGITS;
    localparam int IDX_W = $clog2(DIGITS) + 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DIGITS - 1);

    state_t             r_state;
    logic [SUM_W-1:0]   r_a_sh;
    logic [SUM_W-1:0]   r_b_sh;
    logic [SUM_W-1:0]   r_sum;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic               r_cout;
    logic               r_err;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;

    bcd_digit_t         w_digit_s;
    logic               w_digit_c;
    logic               w_digit_err;
    logic [SUM_W-1:0]   w_sum_next;

    bcd_digit_add u_digit_add (
        .a    (r_a_sh[BCD_W-1:0]),
        .b    (r_b_sh[BCD_W-1:0]),
        .cin  (r_carry),
        .s    (w_digit_s),
        .cout (w_digit_c)
    );

    assign w_digit_err = digit_invalid(r_a_sh[BCD_W-1:0]) |
                         digit_invalid(r_b_sh[BCD_W-1:0]);

    // New digit enters at the top so after DIGITS shifts digit 0 sits at the bottom.
    always_comb begin
        w_sum_next = r_sum >> BCD_W;
        w_sum_next[SUM_W-1 -: BCD_W] = w_digit_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_err       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_a_sh     <= bus.a;
                        r_b_sh     <= bus.b;
                        r_carry    <= bus.cin;
                        r_idx      <= '0;
                        r_err      <= 1'b0;
                        r_cout     <= 1'b0;
                        r_sum      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                RUN: begin
                    r_sum   <= w_sum_next;
                    r_a_sh  <= r_a_sh >> BCD_W;
                    r_b_sh  <= r_b_sh >> BCD_W;
                    r_carry <= w_digit_c;
                    r_err   <= r_err | w_digit_err;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == c_last_idx) begin
                        r_cout      <= w_digit_c;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    // Hold everything until the consumer takes the result.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.err       = r_err;
    assign bus.busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_bcd_serial_add_ctrl.sv
// ============================================================================
// Module   : tb_bcd_serial_add_ctrl
// Brief    : Directed self-checking bench for the serial packed-BCD adder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_serial_add_ctrl;

    localparam int DIGITS = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) ifc ();

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one accept edge, then drop in_valid.
    task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic c);
        ifc.a        = a;
        ifc.b        = b;
        ifc.cin      = c;
        ifc.in_valid = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
    endtask

    // Wait for out_valid; returns the number of edges since the accept edge.
    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!ifc.out_valid && cycles < 40) begin
            tick();
            cycles++;
        end
        if (!ifc.out_valid) chk("out_valid_timeout", 64'(ifc.out_valid), 64'd1);
    endtask

    task automatic take_result(input string tag);
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        chk({tag, "_ov_drop"}, 64'(ifc.out_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(ifc.in_ready), 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic [15:0] exp_sum, input logic exp_cout,
                          input logic exp_err);
        int cyc;
        accept(a, b, c);
        wait_result(cyc);
        chk({tag, "_latency"}, 64'(cyc), 64'(DIGITS));
        chk({tag, "_sum"},  64'(ifc.sum),  64'(exp_sum));
        chk({tag, "_cout"}, 64'(ifc.cout), 64'(exp_cout));
        chk({tag, "_err"},  64'(ifc.err),  64'(exp_err));
        take_result(tag);
    endtask

    initial begin
        int cyc;
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
        ifc.a         = '0;
        ifc.b         = '0;
        ifc.cin       = 1'b0;

        tick();
        tick();
        chk("rst_in_ready",  64'(ifc.in_ready),  64'd0);
        chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("rst_sum",       64'(ifc.sum),       64'd0);
        chk("rst_cout",      64'(ifc.cout),      64'd0);
        chk("rst_err",       64'(ifc.err),       64'd0);
        chk("rst_busy",      64'(ifc.busy),      64'd0);
        rst = 1'b0;
        tick();
        chk("rel_in_ready", 64'(ifc.in_ready), 64'd1);

        run_op("add1234", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
        run_op("add9999", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add0999", 16'h0999, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0);

        // Backpressure: result must sit untouched in DONE.
        accept(16'h4321, 16'h1111, 1'b0);
        wait_result(cyc);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 64'(ifc.out_valid), 64'd1);
            chk("bp_sum",       64'(ifc.sum),       64'h5432);
            chk("bp_cout",      64'(ifc.cout),      64'd0);
            chk("bp_in_ready",  64'(ifc.in_ready),  64'd0);
            chk("bp_busy",      64'(ifc.busy),      64'd1);
            tick();
        end
        take_result("bp");

        // A=0x0A in digit 1 decimal-wraps to 0 with carry into digit 2.
        run_op("badA0", 16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1);
        run_op("after_bad", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Reset two RUN cycles into an operation.
        accept(16'h5555, 16'h5555, 1'b0);
        tick();
        chk("mid_busy", 64'(ifc.busy), 64'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("mid_rst_busy",      64'(ifc.busy),      64'd0);
        chk("mid_rst_in_ready",  64'(ifc.in_ready),  64'd0);
        chk("mid_rst_sum",       64'(ifc.sum),       64'd0);
        rst = 1'b0;
        tick();
        chk("mid_rel_in_ready", 64'(ifc.in_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            chk("mid_no_out_valid", 64'(ifc.out_valid), 64'd0);
            tick();
        end
        run_op("add0005", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0);

        // in_valid held with changing operands: only the accepted pair counts.
        ifc.a        = 16'h1111;
        ifc.b        = 16'h2222;
        ifc.cin      = 1'b0;
        ifc.in_valid = 1'b1;
        tick();
        cyc = 0;
        while (!ifc.out_valid && cyc < 40) begin
            ifc.a   = 16'h9999;
            ifc.b   = 16'h8888 + 16'(cyc);
            ifc.cin = 1'b1;
            tick();
            cyc++;
        end
        chk("hold_latency", 64'(cyc), 64'(DIGITS));
        chk("hold_sum",     64'(ifc.sum),  64'h3333);
        chk("hold_cout",    64'(ifc.cout), 64'd0);
        chk("hold_in_ready", 64'(ifc.in_ready), 64'd0);
        ifc.in_valid = 1'b0;
        take_result("hold");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
